alarm_timekeeper: RTL
=====================

// Module: alarm_timekeeper
// PURPOSE
//  Consumes the 1 Hz square wave from the clock divider (tick_in) and keeps wall time HH:MM:SS in BCD.
//  Holds a user-set alarm time HH:MM and runs the set/alarm state machine.
//  Drives the display digits and the buzzer enable.
//  Sits between the divider and the 7-seg/buzzer drivers, all on the 50 MHz system clock.
// PARAMETERS
//  RING_SECS  60  seconds the alarm rings before auto-stop (1..255)
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  reset, asynchronous, active-low
//  tick_in    in   1  divider output; each rising edge = 1 s
//  set_time   in   1  level: time-set mode (priority over set_alarm)
//  set_alarm  in   1  level: alarm-set mode
//  inc_min    in   1  1-clk pulse (pre-debounced): +1 minute in set modes
//  inc_hour   in   1  1-clk pulse (pre-debounced): +1 hour in set modes
//  alarm_en   in   1  level: alarm armed
//  stop       in   1  1-clk pulse: dismiss ringing alarm
//  disp_hh    out  8  BCD hours: alarm hours in SET_ALARM, else time
//  disp_mm    out  8  BCD minutes: same mux as disp_hh
//  disp_ss    out  8  BCD seconds of time, always
//  ringing    out  1  high in RINGING state
//  buzzer     out  1  ringing AND synchronised tick_in level (0.5 s on/off beep)
// BEHAVIOUR
//  Reset (rst=0, async): time 00:00:00; alarm 00:00; state RUN; ringing=0; buzzer=0; sync/edge flops=0.
//  tick_in passes a 2-flop synchroniser, then a rising-edge detect gives a 1-clk tick.
//  Latency: tick_in rise sampled at edge k -> seconds update at edge k+2. A long-high tick_in counts once.
//  Counting on tick (RUN, SET_ALARM, RINGING):
//   ss 59->00 carries into mm; mm 59->00 carries into hh; hh 23->00.
//   Each digit stays within 0..9; no invalid BCD is ever stored.
//  States (2-bit):
//   RUN -> SET_TIME if set_time; -> SET_ALARM if set_alarm and not set_time;
//   -> RINGING when alarm_en and the tick makes new time == al_hh:al_mm:00.
//   SET_TIME: ss forced to 00 on entry; ticks ignored.
//    inc_min: mm+1 mod 60, no carry into hh. inc_hour: hh+1 mod 24.
//    Exit to RUN when set_time=0; counting resumes from 00 seconds.
//   SET_ALARM: time keeps running; inc_min/inc_hour edit al_mm/al_hh (mod 60/24, no carry).
//    Exit to RUN when set_alarm=0; -> SET_TIME if set_time rises.
//    The alarm never fires in SET_ALARM.
//   RINGING: time keeps running; ring_cnt counts ticks.
//    -> RUN on the first of: stop pulse, alarm_en=0, ring_cnt reaching RING_SECS.
//    -> SET_TIME if set_time (ring cancelled). Exit takes effect on the next edge.
//  inc_min and inc_hour in the same cycle: both applied.
//  inc pulses outside set modes: ignored.
//  A tick coinciding with an inc in SET_ALARM: both take effect; they touch disjoint registers.
//  Alarm at 00:00 fires at midnight rollover.
//  alarm_en=0 blocks triggering. Re-arming mid-minute does not fire until the next HH:MM:00 match.
//  Reset mid-ring or mid-set: immediate return to reset values; no pending pulses survive.
//  All outputs are registered, except disp_* (mux of registers) and buzzer (AND of two registers).
// STRUCTURE
//  Shared package alarm_pkg:
//   state encodings RUN/SET_TIME/SET_ALARM/RINGING
//   constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, BCD_W=8
//  Sub-module bcd_mod_counter:
//   2-digit BCD, parameter MAX; inputs inc, clr; output carry on wrap.
//   Five instances: ss, mm, hh, al_mm, al_hh.
//  The top level holds the synchroniser, edge detect, FSM, ring_cnt, compare and display mux.
// TESTING (drive tick_in directly as a 20-clk-period square wave)
//  1 Rollover: set 23:59 via SET_TIME, exit, 60 ticks -> disp 00:00:00; hh carries exactly at the 60th tick.
//  2 Set wrap: SET_TIME at 00:59, inc_min -> 00:00 (hh stays 00); 25 inc_hour -> hh=01; concurrent inc_min+inc_hour -> both step.
//  3 Alarm fire/stop: alarm 00:02, alarm_en=1, from 00:00:00 give 120 ticks.
//    ringing rises 2 clks after the 120th tick_in rise (edge k+2); buzzer follows tick_in.
//    stop pulse -> ringing=0 next edge.
//  4 Timeout: RING_SECS=4, trigger as in 3 -> ringing drops on the 4th tick after entry; alarm_en=0 mid-ring also clears it.
//  5 Sync/edge: tick_in held high 50 clks, or toggled once -> ss advances by exactly 1.
//  6 Async reset: rst low mid-RINGING at 12:34:56 -> all outputs 0/00 before the next clk edge; RUN after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared states, limits and BCD helpers for the alarm timekeeper
package alarm_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RINGING   = 2'd3
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;
    localparam int BCD_W   = 8;

    function automatic logic [BCD_W-1:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_bcd.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] max_bcd);
        if (v == max_bcd)
            return '0;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter 0..MAX with clear and wrap carry
module bcd_mod_counter
    import alarm_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX);

    assign carry = inc && !clr && (q == MAX_BCD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= bcd_inc(q, MAX_BCD);
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - BCD wall clock with settable alarm, ring timeout and buzzer gate
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       alarm_en,
    input  logic       stop,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic [7:0] disp_ss,
    output logic       ringing,
    output logic       buzzer
);

    localparam logic [BCD_W-1:0] MIN_MAX_BCD = to_bcd(MIN_MAX);
    localparam logic [BCD_W-1:0] HR_MAX_BCD  = to_bcd(HR_MAX);

    state_t           state, state_nxt;
    logic             sync1, sync2, sync3, tick;
    logic [BCD_W-1:0] ss, mm, hh, al_mm, al_hh;
    logic [BCD_W-1:0] mm_new, hh_new;
    logic [7:0]       ring_cnt;
    logic             ss_carry, mm_carry;
    logic             hh_carry_unused, al_mm_carry_unused, al_hh_carry_unused;
    logic             in_set_time, in_set_alarm, count, alarm_hit, ring_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick         = sync2 && !sync3;
    assign in_set_time  = (state == SET_TIME);
    assign in_set_alarm = (state == SET_ALARM);
    assign count        = tick && !in_set_time;

    // In SET_TIME the minute wrap from inc_min must not reach the hours.
    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk(clk), .rst(rst), .inc(count), .clr(in_set_time), .q(ss), .carry(ss_carry));
    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk(clk), .rst(rst), .inc(ss_carry || (in_set_time && inc_min)), .clr(1'b0),
        .q(mm), .carry(mm_carry));
    bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
        .clk(clk), .rst(rst), .inc((mm_carry && !in_set_time) || (in_set_time && inc_hour)),
        .clr(1'b0), .q(hh), .carry(hh_carry_unused));
    bcd_mod_counter #(.MAX(MIN_MAX)) u_al_mm (
        .clk(clk), .rst(rst), .inc(in_set_alarm && inc_min), .clr(1'b0),
        .q(al_mm), .carry(al_mm_carry_unused));
    bcd_mod_counter #(.MAX(HR_MAX)) u_al_hh (
        .clk(clk), .rst(rst), .inc(in_set_alarm && inc_hour), .clr(1'b0),
        .q(al_hh), .carry(al_hh_carry_unused));

    // Compare against the time this tick is about to produce, so ringing rises with it.
    assign mm_new    = ss_carry ? bcd_inc(mm, MIN_MAX_BCD) : mm;
    assign hh_new    = mm_carry ? bcd_inc(hh, HR_MAX_BCD) : hh;
    assign alarm_hit = (state == RUN) && alarm_en && ss_carry &&
                       (mm_new == al_mm) && (hh_new == al_hh);
    assign ring_done = tick && (ring_cnt == 8'(RING_SECS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (set_time)       state_nxt = SET_TIME;
                else if (set_alarm) state_nxt = SET_ALARM;
                else if (alarm_hit) state_nxt = RINGING;
            end
            SET_TIME: begin
                if (!set_time)      state_nxt = RUN;
            end
            SET_ALARM: begin
                if (set_time)       state_nxt = SET_TIME;
                else if (!set_alarm) state_nxt = RUN;
            end
            RINGING: begin
                if (set_time)       state_nxt = SET_TIME;
                else if (stop || !alarm_en || ring_done) state_nxt = RUN;
            end
            default:                state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            ringing  <= 1'b0;
            ring_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ringing  <= (state_nxt == RINGING);
            ring_cnt <= (state != RINGING) ? 8'd0 : ring_cnt + {7'd0, tick};
        end
    end

    assign disp_hh = in_set_alarm ? al_hh : hh;
    assign disp_mm = in_set_alarm ? al_mm : mm;
    assign disp_ss = ss;
    assign buzzer  = ringing && sync2;

endmodule
